// File: rtl/wave_frame_tx.sv
// wave_frame_tx: collects waveform samples into ping-pong banks and streams
// 76-byte frames (A5, 64 samples, HR, SpO2, 8x00, checksum) over valid/ready.
module wave_frame_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wave_data,
  input  logic       wave_valid,
  input  logic [7:0] hr_data,
  input  logic [7:0] spo2_data,
  input  logic       meas_valid,
  output logic [7:0] odata,
  output logic       odata_valid,
  input  logic       odata_ready,
  output logic       frame_busy,
  output logic       ovf
);
  typedef enum logic [2:0] {IDLE, HEAD, WAVE, MEAS, PAD, SUM} state_t;
  state_t state, state_nx;
  logic [7:0] mem [0:1][0:63];
  logic [5:0] wptr, ridx;
  logic       wbank, rbank, pend, acc, full_wr, start;
  logic [6:0] bidx;
  logic [7:0] hr_r, spo2_r, hr_s, spo2_s, csum;

  assign odata_valid = state != IDLE;
  assign frame_busy  = state != IDLE;
  assign acc         = odata_valid && odata_ready;
  assign full_wr     = wave_valid && !pend && wptr == 6'd63;
  // a full bank waiting behind a finished frame starts exactly like a fresh fill
  assign start       = state == IDLE && (pend || full_wr);
  assign ridx        = bidx[5:0] - 6'd1;

  always_comb begin
    state_nx = start ? HEAD :
               !acc ? state :
               state == HEAD ? WAVE :
               state == WAVE && bidx == 7'd64 ? MEAS :
               state == MEAS && bidx == 7'd66 ? PAD :
               state == PAD  && bidx == 7'd74 ? SUM :
               state == SUM ? IDLE : state;
    odata = state == HEAD ? 8'hA5 :
            state == WAVE ? mem[rbank][ridx] :
            state == MEAS ? (bidx == 7'd65 ? hr_s : spo2_s) :
            state == SUM  ? csum : 8'h00;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_ff @(posedge clk)
    if (wave_valid && !pend) mem[wbank][wptr] <= wave_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0; wbank <= 1'b0; rbank <= 1'b0; pend <= 1'b0; ovf <= 1'b0;
      bidx <= '0; csum <= '0; hr_r <= '0; spo2_r <= '0; hr_s <= '0; spo2_s <= '0;
    end else begin
      if (meas_valid) begin
        hr_r   <= hr_data;
        spo2_r <= spo2_data;
      end
      if (wave_valid && pend) ovf <= 1'b1;
      if (start) begin
        rbank  <= wbank;
        wbank  <= ~wbank;
        wptr   <= '0;
        pend   <= 1'b0;
        bidx   <= '0;
        csum   <= '0;
        hr_s   <= hr_r;
        spo2_s <= spo2_r;
      end else if (wave_valid && !pend) begin
        if (wptr == 6'd63) pend <= 1'b1;
        else               wptr <= wptr + 6'd1;
      end
      if (acc) begin
        bidx <= bidx + 7'd1;
        if (bidx != 7'd0 && bidx < 7'd75) csum <= csum + odata;
      end
    end
  end
endmodule

// File: tb/tb_wave_frame_tx.sv
// tb_wave_frame_tx: scoreboard bench; expected frame bytes are queued as samples
// are driven and popped as the DUT hands bytes over.
module tb_wave_frame_tx;
  logic       clk = 0, rst = 1;
  logic [7:0] wave_data = 0, hr_data = 0, spo2_data = 0;
  logic       wave_valid = 0, meas_valid = 0, odata_ready = 1, tog = 0;
  logic [7:0] odata;
  logic       odata_valid, frame_busy, ovf;
  logic [7:0] exp_q[$];
  logic [7:0] held;
  logic       stall = 0;
  int         checks = 0, errors = 0;

  typedef struct {
    logic [7:0] base, hr, spo2, sum;
    logic       toggle;
  } vec_t;
  vec_t vecs[4];

  wave_frame_tx dut (
    .clk(clk), .rst(rst), .wave_data(wave_data), .wave_valid(wave_valid),
    .hr_data(hr_data), .spo2_data(spo2_data), .meas_valid(meas_valid),
    .odata(odata), .odata_valid(odata_valid), .odata_ready(odata_ready),
    .frame_busy(frame_busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) stall = 0;
    else begin
      if (stall) chk("stable", {odata_valid, odata}, {1'b1, held});
      stall = odata_valid && !odata_ready;
      held  = odata;
      if (odata_valid && odata_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {1'b1, odata}, 9'h000);
        else chk("byte", {1'b0, odata}, {1'b0, exp_q.pop_front()});
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (tog) odata_ready = ~odata_ready;
  end

  task automatic push_frame(input logic [7:0] base, h, s, input int sum);
    logic [7:0] c;
    c = h + s;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(base + 8'(i));
      c += base + 8'(i);
    end
    exp_q.push_back(h);
    exp_q.push_back(s);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    exp_q.push_back(sum < 0 ? c : 8'(sum));
  endtask

  task automatic send(input logic [7:0] d);
    wave_data = d; wave_valid = 1;
    @(posedge clk); #1;
    wave_valid = 0;
  endtask

  task automatic meas(input logic [7:0] h, s);
    hr_data = h; spo2_data = s; meas_valid = 1;
    @(posedge clk); #1;
    meas_valid = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin cyc(1); n++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 9'(exp_q.size()), 9'h000);
      exp_q.delete();
    end
  endtask

  task automatic wait_size(input int sz, input string name);
    int n;
    n = 0;
    while (exp_q.size() != sz && n < 3000) begin cyc(1); n++; end
    if (exp_q.size() != sz) chk(name, 9'(exp_q.size()), 9'(sz));
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'd75,  8'd98,  8'h8D, 1'b0};
    vecs[1] = '{8'h00, 8'd75,  8'd98,  8'h8D, 1'b1};
    vecs[2] = '{8'hC0, 8'd200, 8'd100, 8'h0C, 1'b0};
    vecs[3] = '{8'h10, 8'd255, 8'd0,   8'hDF, 1'b1};

    cyc(2);
    chk("rst_odata", {1'b0, odata}, 9'h000);
    chk("rst_valid", {8'h0, odata_valid}, 9'h000);
    chk("rst_busy", {8'h0, frame_busy}, 9'h000);
    chk("rst_ovf", {8'h0, ovf}, 9'h000);
    rst = 0;
    cyc(1);

    foreach (vecs[k]) begin
      tog = vecs[k].toggle;
      odata_ready = 1;
      meas(vecs[k].hr, vecs[k].spo2);
      push_frame(vecs[k].base, vecs[k].hr, vecs[k].spo2, int'(vecs[k].sum));
      for (int i = 0; i < 64; i++) send(vecs[k].base + 8'(i));
      chk("hdr_valid", {8'h0, odata_valid}, 9'h001);
      chk("hdr_byte", {1'b0, odata}, 9'h0A5);
      chk("hdr_busy", {8'h0, frame_busy}, 9'h001);
      drain();
      tog = 0;
      odata_ready = 1;
      cyc(2);
      chk("idle_valid", {8'h0, odata_valid}, 9'h000);
      chk("idle_busy", {8'h0, frame_busy}, 9'h000);
    end

    // 128 back-to-back samples: second frame after exactly one gap cycle
    meas(8'd60, 8'd97);
    push_frame(8'h00, 8'd60, 8'd97, -1);
    push_frame(8'h40, 8'd60, 8'd97, -1);
    for (int i = 0; i < 128; i++) send(8'(i));
    wait_size(76, "first_frame_end");
    chk("gap_valid", {8'h0, odata_valid}, 9'h000);
    cyc(1);
    chk("f2_hdr_valid", {8'h0, odata_valid}, 9'h001);
    chk("f2_hdr_byte", {1'b0, odata}, 9'h0A5);
    drain();
    chk("b2b_ovf", {8'h0, ovf}, 9'h000);

    // measurement change mid-frame lands only in the next frame
    meas(8'd10, 8'd90);
    push_frame(8'h00, 8'd10, 8'd90, -1);
    for (int i = 0; i < 64; i++) send(8'(i));
    cyc(10);
    meas(8'hFF, 8'd90);
    push_frame(8'h40, 8'hFF, 8'd90, -1);
    for (int i = 64; i < 128; i++) send(8'(i));
    drain();

    // stalled sink: 129th sample overflows and is dropped
    odata_ready = 0;
    push_frame(8'h00, 8'hFF, 8'd90, -1);
    push_frame(8'h40, 8'hFF, 8'd90, -1);
    for (int i = 0; i < 128; i++) send(8'(i));
    chk("ovf_before", {8'h0, ovf}, 9'h000);
    send(8'd128);
    chk("ovf_after", {8'h0, ovf}, 9'h001);
    cyc(3);
    odata_ready = 1;
    drain();
    chk("ovf_sticky", {8'h0, ovf}, 9'h001);

    // reset mid-frame at bidx 30
    push_frame(8'h20, 8'hFF, 8'd90, -1);
    for (int i = 0; i < 64; i++) send(8'h20 + 8'(i));
    wait_size(46, "reach_bidx30");
    #1 rst = 1;
    #1;
    chk("abort_valid", {8'h0, odata_valid}, 9'h000);
    chk("abort_busy", {8'h0, frame_busy}, 9'h000);
    chk("abort_ovf", {8'h0, ovf}, 9'h000);
    exp_q.delete();
    cyc(1);
    rst = 0;
    cyc(1);
    push_frame(8'h80, 8'h00, 8'h00, -1);
    for (int i = 0; i < 64; i++) send(8'h80 + 8'(i));
    chk("post_rst_hdr", {odata_valid, odata}, 9'h1A5);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
